ps_memory: RTL and testbench

Load/store stage directly downstream of the execute stage. Takes the execute stage's memory-request outputs, issues a single outstanding access to the data-memory bus with a req/ack handshake, and sizes and aligns store data and byte enables. It sign- or zero-extends returned load data and hands the result, tagged with its destination, to writeback. While an access is in flight it stalls the pipeline and flags misaligned or timed-out accesses.

---
 rtl/ps_pkg.sv | 36 +++
 rtl/ps_mem_align.sv | 60 ++++++
 rtl/ps_memory.sv | 216 +++++++++++++++++++++
 tb/tb_ps_memory.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_pkg.sv
// Shared encodings for the load/store stage: access types, size codes and FSM states.
package ps_pkg;

   localparam int RD_ADD_W = 7;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_B    = 3'd1;
   localparam logic [2:0] LD_H    = 3'd2;
   localparam logic [2:0] LD_W    = 3'd3;
   localparam logic [2:0] LD_BU   = 3'd5;
   localparam logic [2:0] LD_HU   = 3'd6;

   localparam logic [2:0] ST_NONE = 3'd0;
   localparam logic [2:0] ST_B    = 3'd1;
   localparam logic [2:0] ST_H    = 3'd2;
   localparam logic [2:0] ST_W    = 3'd3;

   // Access size lives in the low two bits of both load and store encodings.
   localparam logic [1:0] SZ_B = 2'd1;
   localparam logic [1:0] SZ_H = 2'd2;
   localparam logic [1:0] SZ_W = 2'd3;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } ps_state_e;

   function automatic logic ld_is_valid(input logic [2:0] t);
      return (t == LD_B) || (t == LD_H) || (t == LD_W) || (t == LD_BU) || (t == LD_HU);
   endfunction

   function automatic logic st_is_valid(input logic [2:0] t);
      return (t == ST_B) || (t == ST_H) || (t == ST_W);
   endfunction

endpackage

// File: rtl/ps_mem_align.sv
// Byte-enable generation, misalignment detection and load lane extraction/extension.
module ps_mem_align
   import ps_pkg::*;
(
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_off,
   output logic [3:0]  req_be,
   output logic        req_misalign,
   input  logic [2:0]  ld_type,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   function automatic logic signed [31:0] sext8(input logic signed [7:0] v);
      return 32'(v);
   endfunction

   function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
      return 32'(v);
   endfunction

   always_comb begin
      req_be       = 4'b0000;
      req_misalign = 1'b0;
      case (req_size)
         SZ_B: req_be = 4'b0001 << req_off;
         SZ_H: begin
            req_be       = req_off[1] ? 4'b1100 : 4'b0011;
            req_misalign = req_off[0];
         end
         SZ_W: begin
            req_be       = 4'b1111;
            req_misalign = |req_off;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_off)
         2'd0:    byte_sel = ld_word[7:0];
         2'd1:    byte_sel = ld_word[15:8];
         2'd2:    byte_sel = ld_word[23:16];
         default: byte_sel = ld_word[31:24];
      endcase
      half_sel = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_type)
         LD_B:    ld_data = sext8(byte_sel);
         LD_BU:   ld_data = {24'd0, byte_sel};
         LD_H:    ld_data = sext16(half_sel);
         LD_HU:   ld_data = {16'd0, half_sel};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/ps_memory.sv
// Load/store stage: single outstanding data-memory access with req/ack handshake,
// store sizing, load extension, misalign/timeout error reporting.
module ps_memory
   import ps_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pause,
   input  logic [2:0]          ex_mem_ren,
   input  logic [31:0]         ex_mem_radd,
   input  logic [RD_ADD_W-1:0] ex_mem_rd_add,
   input  logic [2:0]          ex_mem_wen,
   input  logic [31:0]         ex_mem_wadd,
   input  logic [31:0]         ex_mem_wdata,
   output logic                dm_req,
   output logic                dm_we,
   output logic [31:0]         dm_addr,
   output logic [3:0]          dm_be,
   output logic [31:0]         dm_wdata,
   input  logic                dm_ack,
   input  logic [31:0]         dm_rdata,
   output logic                mem_rd_en,
   output logic [RD_ADD_W-1:0] mem_rd_add,
   output logic [31:0]         mem_rd_data,
   output logic                mem_pause,
   output logic                mem_err,
   output logic [31:0]         mem_err_addr
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   ps_state_e           state_q, state_d;
   logic [7:0]          wait_q, wait_d;
   logic                dm_req_q, dm_req_d;
   logic                dm_we_q, dm_we_d;
   logic [31:0]         dm_addr_q, dm_addr_d;
   logic [3:0]          dm_be_q, dm_be_d;
   logic [31:0]         dm_wdata_q, dm_wdata_d;
   logic [2:0]          ld_type_q, ld_type_d;
   logic [1:0]          off_q, off_d;
   logic [RD_ADD_W-1:0] rd_tag_q, rd_tag_d;
   logic [31:0]         byte_addr_q, byte_addr_d;
   logic                mem_rd_en_q, mem_rd_en_d;
   logic [RD_ADD_W-1:0] mem_rd_add_q, mem_rd_add_d;
   logic [31:0]         mem_rd_data_q, mem_rd_data_d;
   logic                mem_err_q, mem_err_d;
   logic [31:0]         mem_err_addr_q, mem_err_addr_d;
   logic                err_pend_q, err_pend_d;
   logic [31:0]         err_pend_addr_q, err_pend_addr_d;

   logic        ld_ok, st_ok, acc_ok, capture;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic        req_misalign;
   logic [31:0] ld_data;
   logic        err_new;
   logic [31:0] err_new_addr;

   ps_mem_align u_align (
      .req_size     (req_size),
      .req_off      (req_addr[1:0]),
      .req_be       (req_be),
      .req_misalign (req_misalign),
      .ld_type      (ld_type_q),
      .ld_off       (off_q),
      .ld_word      (dm_rdata),
      .ld_data      (ld_data)
   );

   // Load wins when both a load and a store are presented together.
   always_comb begin
      ld_ok    = ld_is_valid(ex_mem_ren);
      st_ok    = st_is_valid(ex_mem_wen);
      acc_ok   = ld_ok || st_ok;
      req_size = ld_ok ? ex_mem_ren[1:0] : ex_mem_wen[1:0];
      req_addr = ld_ok ? ex_mem_radd : ex_mem_wadd;
      capture  = acc_ok && !pause &&
                 ((state_q == S_IDLE) || ((state_q == S_BUSY) && dm_ack));
   end

   always_comb begin
      state_d         = state_q;
      wait_d          = wait_q;
      dm_req_d        = dm_req_q;
      dm_we_d         = dm_we_q;
      dm_addr_d       = dm_addr_q;
      dm_be_d         = dm_be_q;
      dm_wdata_d      = dm_wdata_q;
      ld_type_d       = ld_type_q;
      off_d           = off_q;
      rd_tag_d        = rd_tag_q;
      byte_addr_d     = byte_addr_q;
      mem_rd_en_d     = 1'b0;
      mem_rd_add_d    = mem_rd_add_q;
      mem_rd_data_d   = mem_rd_data_q;
      mem_err_d       = 1'b0;
      mem_err_addr_d  = mem_err_addr_q;
      err_pend_d      = 1'b0;
      err_pend_addr_d = err_pend_addr_q;
      err_new         = 1'b0;
      err_new_addr    = 32'd0;

      if (state_q == S_BUSY) begin
         if (dm_ack) begin
            if (ld_type_q != LD_NONE) begin
               mem_rd_en_d   = 1'b1;
               mem_rd_add_d  = rd_tag_q;
               mem_rd_data_d = ld_data;
            end
            state_d  = S_IDLE;
            dm_req_d = 1'b0;
            wait_d   = 8'd0;
         end else if (wait_q == WAIT_LAST) begin
            state_d      = S_IDLE;
            dm_req_d     = 1'b0;
            wait_d       = 8'd0;
            err_new      = 1'b1;
            err_new_addr = byte_addr_q;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end

      if (capture) begin
         if (req_misalign) begin
            err_new      = 1'b1;
            err_new_addr = req_addr;
         end else begin
            state_d     = S_BUSY;
            dm_req_d    = 1'b1;
            wait_d      = 8'd0;
            dm_we_d     = !ld_ok;
            dm_addr_d   = {req_addr[31:2], 2'b00};
            dm_be_d     = req_be;
            dm_wdata_d  = ex_mem_wdata;
            ld_type_d   = ld_ok ? ex_mem_ren : LD_NONE;
            off_d       = req_addr[1:0];
            rd_tag_d    = ex_mem_rd_add;
            byte_addr_d = req_addr;
         end
      end

      // An error raised alongside a load writeback is held one cycle so the two
      // pulses never coincide; a held error always drains while the FSM is idle.
      if (err_pend_q) begin
         mem_err_d      = 1'b1;
         mem_err_addr_d = err_pend_addr_q;
         err_pend_d     = err_new;
         if (err_new) err_pend_addr_d = err_new_addr;
      end else if (err_new && mem_rd_en_d) begin
         err_pend_d      = 1'b1;
         err_pend_addr_d = err_new_addr;
      end else if (err_new) begin
         mem_err_d      = 1'b1;
         mem_err_addr_d = err_new_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         wait_q          <= 8'd0;
         dm_req_q        <= 1'b0;
         dm_we_q         <= 1'b0;
         dm_addr_q       <= 32'd0;
         dm_be_q         <= 4'd0;
         dm_wdata_q      <= 32'd0;
         ld_type_q       <= LD_NONE;
         off_q           <= 2'd0;
         rd_tag_q        <= '0;
         byte_addr_q     <= 32'd0;
         mem_rd_en_q     <= 1'b0;
         mem_rd_add_q    <= '0;
         mem_rd_data_q   <= 32'd0;
         mem_err_q       <= 1'b0;
         mem_err_addr_q  <= 32'd0;
         err_pend_q      <= 1'b0;
         err_pend_addr_q <= 32'd0;
      end else begin
         state_q         <= state_d;
         wait_q          <= wait_d;
         dm_req_q        <= dm_req_d;
         dm_we_q         <= dm_we_d;
         dm_addr_q       <= dm_addr_d;
         dm_be_q         <= dm_be_d;
         dm_wdata_q      <= dm_wdata_d;
         ld_type_q       <= ld_type_d;
         off_q           <= off_d;
         rd_tag_q        <= rd_tag_d;
         byte_addr_q     <= byte_addr_d;
         mem_rd_en_q     <= mem_rd_en_d;
         mem_rd_add_q    <= mem_rd_add_d;
         mem_rd_data_q   <= mem_rd_data_d;
         mem_err_q       <= mem_err_d;
         mem_err_addr_q  <= mem_err_addr_d;
         err_pend_q      <= err_pend_d;
         err_pend_addr_q <= err_pend_addr_d;
      end
   end

   assign dm_req       = dm_req_q;
   assign dm_we        = dm_we_q;
   assign dm_addr      = dm_addr_q;
   assign dm_be        = dm_be_q;
   assign dm_wdata     = dm_wdata_q;
   assign mem_rd_en    = mem_rd_en_q;
   assign mem_rd_add   = mem_rd_add_q;
   assign mem_rd_data  = mem_rd_data_q;
   assign mem_err      = mem_err_q;
   assign mem_err_addr = mem_err_addr_q;
   assign mem_pause    = (state_q == S_BUSY) && !dm_ack;

endmodule

// File: tb/tb_ps_memory.sv
// Self-checking bench for ps_memory: directed cases plus randomized transactions
// checked against a transaction-level reference model.
module tb_ps_memory;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        pause;
   logic [2:0]  ex_mem_ren;
   logic [31:0] ex_mem_radd;
   logic [6:0]  ex_mem_rd_add;
   logic [2:0]  ex_mem_wen;
   logic [31:0] ex_mem_wadd;
   logic [31:0] ex_mem_wdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        mem_rd_en;
   logic [6:0]  mem_rd_add;
   logic [31:0] mem_rd_data;
   logic        mem_pause;
   logic        mem_err;
   logic [31:0] mem_err_addr;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ps_memory #(.TIMEOUT(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .pause         (pause),
      .ex_mem_ren    (ex_mem_ren),
      .ex_mem_radd   (ex_mem_radd),
      .ex_mem_rd_add (ex_mem_rd_add),
      .ex_mem_wen    (ex_mem_wen),
      .ex_mem_wadd   (ex_mem_wadd),
      .ex_mem_wdata  (ex_mem_wdata),
      .dm_req        (dm_req),
      .dm_we         (dm_we),
      .dm_addr       (dm_addr),
      .dm_be         (dm_be),
      .dm_wdata      (dm_wdata),
      .dm_ack        (dm_ack),
      .dm_rdata      (dm_rdata),
      .mem_rd_en     (mem_rd_en),
      .mem_rd_add    (mem_rd_add),
      .mem_rd_data   (mem_rd_data),
      .mem_pause     (mem_pause),
      .mem_err       (mem_err),
      .mem_err_addr  (mem_err_addr)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model helpers, expressed in bytes and plain arithmetic.
   function automatic int m_bytes(input logic [2:0] t);
      case (t)
         3'd1, 3'd5: return 1;
         3'd2, 3'd6: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
      int n;
      n = m_bytes(t);
      if (n == 4) return 4'hF;
      if (n == 2) return 4'((3 << (a % 4)) & 15);
      return 4'((1 << (a % 4)) & 15);
   endfunction

   function automatic logic [31:0] m_ext(input logic [2:0] t, input int off, input logic [31:0] w);
      logic [31:0] v;
      case (t)
         3'd1, 3'd5: begin
            v = (w >> (8 * off)) & 32'hFF;
            if (t == 3'd1 && v >= 32'd128) v = v | 32'hFFFF_FF00;
         end
         3'd2, 3'd6: begin
            v = (w >> (8 * (off & 2))) & 32'hFFFF;
            if (t == 3'd2 && v >= 32'd32768) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   task automatic clear_inputs();
      ex_mem_ren = 3'd0;
      ex_mem_wen = 3'd0;
      dm_ack     = 1'b0;
      pause      = 1'b0;
   endtask

   // One complete access from IDLE; ack_delay >= TO means no ack (timeout).
   task automatic do_access(input logic is_ld, input logic [2:0] typ, input logic [31:0] addr,
                            input logic [6:0] rd, input logic [31:0] wd, input int ack_delay,
                            input logic [31:0] rdata, input logic both);
      logic mis;
      mis = (addr % m_bytes(typ)) != 0;
      ex_mem_rd_add = rd;
      ex_mem_wdata  = wd;
      pause         = 1'b0;
      if (is_ld) begin
         ex_mem_ren  = typ;
         ex_mem_radd = addr;
         ex_mem_wen  = both ? 3'($urandom_range(1, 3)) : 3'd0;
         ex_mem_wadd = $urandom;
      end else begin
         ex_mem_ren  = 3'd0;
         ex_mem_wen  = typ;
         ex_mem_wadd = addr;
      end
      #1;
      check_val("idle_pause", 32'(mem_pause), 32'd0);
      step();
      ex_mem_ren = 3'd0;
      ex_mem_wen = 3'd0;
      if (mis) begin
         check_val("mis_req", 32'(dm_req), 32'd0);
         check_val("mis_err", 32'(mem_err), 32'd1);
         check_val("mis_err_addr", mem_err_addr, addr);
         check_val("mis_rd_en", 32'(mem_rd_en), 32'd0);
         step();
         check_val("mis_err_pulse", 32'(mem_err), 32'd0);
         return;
      end
      check_val("req_rise", 32'(dm_req), 32'd1);
      check_val("req_addr", dm_addr, addr & 32'hFFFF_FFFC);
      check_val("req_be", 32'(dm_be), 32'(m_be(typ, addr)));
      check_val("req_we", 32'(dm_we), 32'(!is_ld));
      if (!is_ld) check_val("req_wdata", dm_wdata, wd);
      for (int c = 0; c < int'(TO); c++) begin
         if (c == ack_delay) begin
            dm_ack   = 1'b1;
            dm_rdata = rdata;
            pause    = 1'($urandom % 2);
            #1;
            check_val("ack_pause", 32'(mem_pause), 32'd0);
            step();
            dm_ack = 1'b0;
            pause  = 1'b0;
            check_val("done_req", 32'(dm_req), 32'd0);
            check_val("done_rd_en", 32'(mem_rd_en), 32'(is_ld));
            check_val("done_err", 32'(mem_err), 32'd0);
            if (is_ld) begin
               check_val("ld_data", mem_rd_data, m_ext(typ, int'(addr % 4), rdata));
               check_val("ld_rd_add", 32'(mem_rd_add), 32'(rd));
            end
            step();
            check_val("wb_pulse", 32'(mem_rd_en), 32'd0);
            return;
         end
         pause = 1'($urandom % 2);
         #1;
         check_val("wait_pause", 32'(mem_pause), 32'd1);
         check_val("wait_req", 32'(dm_req), 32'd1);
         step();
         pause = 1'b0;
      end
      check_val("to_req", 32'(dm_req), 32'd0);
      check_val("to_err", 32'(mem_err), 32'd1);
      check_val("to_err_addr", mem_err_addr, addr);
      check_val("to_rd_en", 32'(mem_rd_en), 32'd0);
      dm_ack = 1'b1;
      step();
      dm_ack = 1'b0;
      check_val("late_ack_rd_en", 32'(mem_rd_en), 32'd0);
      check_val("late_ack_req", 32'(dm_req), 32'd0);
      check_val("late_ack_err", 32'(mem_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [2:0] ld_types [5];
      logic       is_ld;
      logic [2:0] typ;
      ld_types = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
      clear_inputs();
      ex_mem_radd = 32'd0; ex_mem_wadd = 32'd0; ex_mem_wdata = 32'd0;
      ex_mem_rd_add = 7'd0; dm_rdata = 32'd0;
      reset = 1'b1;
      step(); step();
      check_val("rst_req", 32'(dm_req), 32'd0);
      check_val("rst_we", 32'(dm_we), 32'd0);
      check_val("rst_addr", dm_addr, 32'd0);
      check_val("rst_be", 32'(dm_be), 32'd0);
      check_val("rst_wdata", dm_wdata, 32'd0);
      check_val("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check_val("rst_rd_add", 32'(mem_rd_add), 32'd0);
      check_val("rst_rd_data", mem_rd_data, 32'd0);
      check_val("rst_err", 32'(mem_err), 32'd0);
      check_val("rst_err_addr", mem_err_addr, 32'd0);
      check_val("rst_pause", 32'(mem_pause), 32'd0);
      reset = 1'b0;
      step();

      // LW with ack in the third request cycle
      do_access(1'b1, 3'd3, 32'h100, 7'h25, 32'd0, 2, 32'hDEADBEEF, 1'b0);
      check_val("lw_data_abs", mem_rd_data, 32'hDEADBEEF);
      // Extension cases
      do_access(1'b1, 3'd1, 32'h103, 7'h01, 32'd0, 0, 32'h80112233, 1'b0);
      check_val("lb_abs", mem_rd_data, 32'hFFFFFF80);
      do_access(1'b1, 3'd5, 32'h103, 7'h02, 32'd0, 1, 32'h80112233, 1'b0);
      check_val("lbu_abs", mem_rd_data, 32'h00000080);
      do_access(1'b1, 3'd6, 32'h102, 7'h03, 32'd0, 0, 32'h80112233, 1'b0);
      check_val("lhu_abs", mem_rd_data, 32'h00008011);

      // SH acked in first cycle, SB issued back-to-back in the ack cycle
      ex_mem_wen = 3'd2; ex_mem_wadd = 32'h206; ex_mem_wdata = 32'hABCDABCD;
      step();
      ex_mem_wen = 3'd0;
      check_val("sh_we", 32'(dm_we), 32'd1);
      check_val("sh_addr", dm_addr, 32'h204);
      check_val("sh_be", 32'(dm_be), 32'hC);
      check_val("sh_wdata", dm_wdata, 32'hABCDABCD);
      dm_ack = 1'b1; ex_mem_wen = 3'd1; ex_mem_wadd = 32'h301; ex_mem_wdata = 32'h5A5A5A5A;
      #1;
      check_val("b2b_pause", 32'(mem_pause), 32'd0);
      step();
      dm_ack = 1'b0; ex_mem_wen = 3'd0;
      check_val("sb_req", 32'(dm_req), 32'd1);
      check_val("sb_addr", dm_addr, 32'h300);
      check_val("sb_be", 32'(dm_be), 32'h2);
      check_val("sh_no_wb", 32'(mem_rd_en), 32'd0);
      dm_ack = 1'b1;
      step();
      dm_ack = 1'b0;
      check_val("sb_done_req", 32'(dm_req), 32'd0);
      check_val("sb_no_wb", 32'(mem_rd_en), 32'd0);

      // Misaligned word load and timeout
      do_access(1'b1, 3'd3, 32'h102, 7'h04, 32'd0, 0, 32'd0, 1'b0);
      do_access(1'b1, 3'd3, 32'h400, 7'h05, 32'd0, int'(TO), 32'd0, 1'b0);

      // Invalid types are ignored
      ex_mem_ren = 3'd4; ex_mem_wen = 3'd7;
      step();
      ex_mem_ren = 3'd0; ex_mem_wen = 3'd0;
      check_val("inv_req", 32'(dm_req), 32'd0);
      check_val("inv_err", 32'(mem_err), 32'd0);

      // Reset in the middle of BUSY
      ex_mem_ren = 3'd3; ex_mem_radd = 32'h500; ex_mem_rd_add = 7'h11;
      step();
      ex_mem_ren = 3'd0;
      step();
      check_val("rb_req", 32'(dm_req), 32'd1);
      reset = 1'b1; dm_ack = 1'b1;
      step();
      reset = 1'b0; dm_ack = 1'b0;
      check_val("rb_req0", 32'(dm_req), 32'd0);
      check_val("rb_addr0", dm_addr, 32'd0);
      check_val("rb_be0", 32'(dm_be), 32'd0);
      check_val("rb_rd_en", 32'(mem_rd_en), 32'd0);
      check_val("rb_err", 32'(mem_err), 32'd0);
      check_val("rb_pause", 32'(mem_pause), 32'd0);
      step();
      check_val("rb_rd_en2", 32'(mem_rd_en), 32'd0);
      check_val("rb_err2", 32'(mem_err), 32'd0);

      // Pause holds off capture in IDLE
      pause = 1'b1; ex_mem_ren = 3'd3; ex_mem_radd = 32'h40; ex_mem_rd_add = 7'h07;
      step(); step();
      check_val("pz_req", 32'(dm_req), 32'd0);
      check_val("pz_pause", 32'(mem_pause), 32'd0);
      pause = 1'b0;
      step();
      ex_mem_ren = 3'd0;
      check_val("pz_req1", 32'(dm_req), 32'd1);
      check_val("pz_addr", dm_addr, 32'h40);
      dm_ack = 1'b1; dm_rdata = 32'h12345678;
      step();
      dm_ack = 1'b0;
      check_val("pz_rd_en", 32'(mem_rd_en), 32'd1);
      check_val("pz_data", mem_rd_data, 32'h12345678);

      // Misaligned access captured in a load's ack cycle: writeback first, error after
      ex_mem_ren = 3'd3; ex_mem_radd = 32'h10; ex_mem_rd_add = 7'h03;
      step();
      ex_mem_ren = 3'd0;
      check_val("co_req", 32'(dm_req), 32'd1);
      dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
      ex_mem_ren = 3'd3; ex_mem_radd = 32'h12; ex_mem_rd_add = 7'h04;
      step();
      dm_ack = 1'b0; ex_mem_ren = 3'd0;
      check_val("co_rd_en", 32'(mem_rd_en), 32'd1);
      check_val("co_data", mem_rd_data, 32'hCAFEF00D);
      check_val("co_err0", 32'(mem_err), 32'd0);
      check_val("co_req0", 32'(dm_req), 32'd0);
      step();
      check_val("co_rd_en0", 32'(mem_rd_en), 32'd0);
      check_val("co_err1", 32'(mem_err), 32'd1);
      check_val("co_err_addr", mem_err_addr, 32'h12);
      step();
      check_val("co_err_pulse", 32'(mem_err), 32'd0);

      // Randomized transactions
      for (int i = 0; i < 60; i++) begin
         is_ld = 1'($urandom % 2);
         typ   = is_ld ? ld_types[$urandom % 5] : 3'($urandom_range(1, 3));
         do_access(is_ld, typ, $urandom, 7'($urandom), $urandom,
                   int'($urandom_range(0, TO)), $urandom, 1'(is_ld && ($urandom % 4 == 0)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
